// File: rtl/bit_scan_pipe.sv
// Pipelined, handshaked bit-scan unit: counts matching bits (zeros or ones) from either
// end of the operand. The binary-halving search levels are spread over PIPE_STAGES
// elastic register stages; a tag travels alongside each transaction.
module bit_scan_pipe #(
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 6,
  parameter int PIPE_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_count_one,
  input  logic                        in_from_msb,
  input  logic [TAG_WIDTH-1:0]        in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(DATA_WIDTH):0] out_cnt,
  output logic                        out_all,
  output logic [TAG_WIDTH-1:0]        out_tag
);

  localparam int LG     = $clog2(DATA_WIDTH);
  localparam int LEVELS = LG + 1;
  localparam int P      = 1 << LG;
  localparam int CW     = LG + 1;
  localparam int S      = PIPE_STAGES;

  // Stage that evaluates search level k.
  function automatic int stage_of(input int k);
    return (k * PIPE_STAGES) / LEVELS;
  endfunction

  // Highest level evaluated in stage s; its result is what the stage register captures.
  function automatic int last_lvl(input int s);
    int r;
    r = 0;
    for (int k = 0; k < LEVELS; k++) begin
      if (stage_of(k) == s) r = k;
    end
    return r;
  endfunction

  // Stage registers
  logic [S-1:0]                valid_q;
  logic [S-1:0][TAG_WIDTH-1:0] tag_q;
  logic [S-1:0][P-1:0]         win_q;
  logic [S-1:0][LG-1:0]        cnt_q;
  logic [S-1:0]                all_q;

  // Stage register inputs
  logic [S-1:0]                si_valid;
  logic [S-1:0][TAG_WIDTH-1:0] si_tag;
  logic [S-1:0][P-1:0]         si_win;
  logic [S-1:0][LG-1:0]        si_cnt;
  logic [S-1:0]                si_all;

  // Per-level combinational results
  logic [LEVELS-1:0][P-1:0]  lo_win;
  logic [LEVELS-1:0][LG-1:0] lo_cnt;
  logic [LEVELS-1:0]         lo_all;

  logic [DATA_WIDTH-1:0] x_inv;
  logic [DATA_WIDTH-1:0] x_ord;
  logic [P-1:0]          norm;

  // Normalise to "count zeros from bit 0"; pad ones bound the count at DATA_WIDTH.
  always_comb begin
    x_inv = in_count_one ? ~in_data : in_data;
    x_ord = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      x_ord[i] = in_from_msb ? x_inv[DATA_WIDTH-1-i] : x_inv[i];
    end
    norm = '1;
    norm[DATA_WIDTH-1:0] = x_ord;
  end

  assign lo_win[0] = norm;
  assign lo_cnt[0] = '0;
  assign lo_all[0] = ~|x_ord;

  for (genvar k = 1; k < LEVELS; k++) begin : g_lvl
    localparam int H  = P >> k;
    localparam int SK = stage_of(k);
    localparam int SP = stage_of(k - 1);

    logic [P-1:0]  w;
    logic [LG-1:0] c;
    logic [LG-1:0] cn;
    logic          a;
    logic          lz;

    // Take the previous level directly, or from the register when a stage boundary lies between.
    if (SK != SP) begin : g_reg
      assign w = win_q[SP];
      assign c = cnt_q[SP];
      assign a = all_q[SP];
    end else begin : g_comb
      assign w = lo_win[k-1];
      assign c = lo_cnt[k-1];
      assign a = lo_all[k-1];
    end

    assign lz = ~|w[H-1:0];

    // Each halving step contributes one count bit, widest first.
    always_comb begin
      cn         = c;
      cn[LG-k]   = lz;
    end

    assign lo_win[k] = lz ? (w >> H) : w;
    assign lo_cnt[k] = cn;
    assign lo_all[k] = a;
  end

  for (genvar s = 0; s < S; s++) begin : g_stage_in
    localparam int L = last_lvl(s);
    if (s == 0) begin : g_first
      assign si_valid[s] = in_valid;
      assign si_tag[s]   = in_tag;
    end else begin : g_next
      assign si_valid[s] = valid_q[s-1];
      assign si_tag[s]   = tag_q[s-1];
    end
    assign si_win[s] = lo_win[L];
    assign si_cnt[s] = lo_cnt[L];
    assign si_all[s] = lo_all[L];
  end

  logic [S-1:0] full_from;
  logic [S-1:0] rdy;

  // A stage can load unless it and every stage after it are occupied and the output is stalled.
  always_comb begin
    full_from = '0;
    for (int s = 0; s < S; s++) begin
      full_from[s] = 1'b1;
      for (int j = 0; j < S; j++) begin
        if (j >= s) full_from[s] = full_from[s] & valid_q[j];
      end
    end
  end

  assign rdy      = ~full_from | {S{out_ready}};
  assign in_ready = rdy[0];

  // Elastic stage registers; flush wins over every load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      tag_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      all_q   <= '0;
    end else begin
      for (int s = 0; s < S; s++) begin
        if (flush) begin
          valid_q[s] <= 1'b0;
        end else if (rdy[s]) begin
          valid_q[s] <= si_valid[s];
        end
        if (rdy[s] && si_valid[s] && !flush) begin
          tag_q[s] <= si_tag[s];
          win_q[s] <= si_win[s];
          cnt_q[s] <= si_cnt[s];
          all_q[s] <= si_all[s];
        end
      end
    end
  end

  // When every bit matched the halving bits are meaningless; report DATA_WIDTH instead.
  assign out_valid = valid_q[S-1];
  assign out_tag   = tag_q[S-1];
  assign out_all   = all_q[S-1];
  assign out_cnt   = all_q[S-1] ? CW'(DATA_WIDTH) : {1'b0, cnt_q[S-1]};

  // The final window is not needed once the last level has been evaluated.
  logic unused_win;
  assign unused_win = ^win_q[S-1];

endmodule

// File: tb/tb_bit_scan_pipe.sv
// Self-checking bench for bit_scan_pipe: directed vectors on W=32/S=2 and W=20/S=3,
// backpressure, fill, flush and async reset, plus a random run on W=13/S=4.
module tb_bit_scan_pipe;

  localparam int SA = 2;
  localparam int SB = 3;

  logic clk;
  logic rst;
  logic flush;

  int n_checks;
  int n_fail;

  // DUT A: W=32, S=2
  logic        a_in_valid, a_in_ready, a_in_one, a_in_msb, a_out_valid, a_out_ready, a_out_all;
  logic [31:0] a_in_data;
  logic [5:0]  a_in_tag, a_out_tag;
  logic [5:0]  a_out_cnt;

  // DUT B: W=20, S=3
  logic        b_in_valid, b_in_ready, b_in_one, b_in_msb, b_out_valid, b_out_ready, b_out_all;
  logic [19:0] b_in_data;
  logic [3:0]  b_in_tag, b_out_tag;
  logic [5:0]  b_out_cnt;

  // DUT C: W=13, S=4
  logic        c_in_valid, c_in_ready, c_in_one, c_in_msb, c_out_valid, c_out_ready, c_out_all;
  logic [12:0] c_in_data;
  logic [5:0]  c_in_tag, c_out_tag;
  logic [4:0]  c_out_cnt;

  bit_scan_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(6), .PIPE_STAGES(SA)) u_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_count_one(a_in_one), .in_from_msb(a_in_msb), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_cnt(a_out_cnt),
    .out_all(a_out_all), .out_tag(a_out_tag)
  );

  bit_scan_pipe #(.DATA_WIDTH(20), .TAG_WIDTH(4), .PIPE_STAGES(SB)) u_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_count_one(b_in_one), .in_from_msb(b_in_msb), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_cnt(b_out_cnt),
    .out_all(b_out_all), .out_tag(b_out_tag)
  );

  bit_scan_pipe #(.DATA_WIDTH(13), .TAG_WIDTH(6), .PIPE_STAGES(4)) u_c (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .in_count_one(c_in_one), .in_from_msb(c_in_msb), .in_tag(c_in_tag),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_cnt(c_out_cnt),
    .out_all(c_out_all), .out_tag(c_out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: matching bits before the first non-matching one.
  function automatic int ref_cnt(input logic [63:0] d, input int w, input bit one, input bit msb);
    int  c;
    bit  stop;
    c    = 0;
    stop = 1'b0;
    for (int i = 0; i < w; i++) begin
      int b;
      b = msb ? (w - 1 - i) : i;
      if (!stop && (d[b] == one)) c++;
      else stop = 1'b1;
    end
    return c;
  endfunction

  task automatic a_single(input string name, input logic [31:0] d, input bit one, input bit msb,
                          input logic [5:0] tag, input int exp_cnt, input bit exp_all);
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_in_data = d; a_in_one = one; a_in_msb = msb; a_in_tag = tag;
    a_out_ready = 1'b1;
    @(negedge clk);
    check_eq({name, "_in_ready"}, 64'(a_in_ready), 64'd1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    for (int i = 1; i < SA; i++) begin
      check_eq({name, "_early"}, 64'(a_out_valid), 64'd0);
      @(posedge clk); #1;
    end
    check_eq({name, "_valid"}, 64'(a_out_valid), 64'd1);
    check_eq({name, "_cnt"}, 64'(a_out_cnt), 64'(exp_cnt));
    check_eq({name, "_all"}, 64'(a_out_all), 64'(exp_all));
    check_eq({name, "_tag"}, 64'(a_out_tag), 64'(tag));
  endtask

  task automatic b_single(input string name, input logic [19:0] d, input bit one, input bit msb,
                          input logic [3:0] tag, input int exp_cnt, input bit exp_all);
    @(posedge clk); #1;
    b_in_valid = 1'b1; b_in_data = d; b_in_one = one; b_in_msb = msb; b_in_tag = tag;
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    for (int i = 1; i < SB; i++) begin
      check_eq({name, "_early"}, 64'(b_out_valid), 64'd0);
      @(posedge clk); #1;
    end
    check_eq({name, "_valid"}, 64'(b_out_valid), 64'd1);
    check_eq({name, "_cnt"}, 64'(b_out_cnt), 64'(exp_cnt));
    check_eq({name, "_all"}, 64'(b_out_all), 64'(exp_all));
    check_eq({name, "_tag"}, 64'(b_out_tag), 64'(tag));
  endtask

  // Stream table: data, mode, from_msb, hand-computed count and all flag.
  logic [31:0] st_data [8];
  bit          st_one  [8];
  bit          st_msb  [8];
  int          st_cnt  [8];
  bit          st_all  [8];

  task automatic a_drive_st(input int i, input logic [5:0] tag);
    a_in_data = st_data[i]; a_in_one = st_one[i]; a_in_msb = st_msb[i]; a_in_tag = tag;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          tx, rx, acc, got, seen;
    bit          p_stall;
    logic [12:0] p_snap;
    int          q_tag [$];
    int          q_cnt [$];
    bit          c_done;
    int          ctag_n;

    n_checks = 0; n_fail = 0;
    rst = 1'b1; flush = 1'b0;
    a_in_valid = 0; a_in_data = '0; a_in_one = 0; a_in_msb = 0; a_in_tag = '0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = '0; b_in_one = 0; b_in_msb = 0; b_in_tag = '0; b_out_ready = 0;
    c_in_valid = 0; c_in_data = '0; c_in_one = 0; c_in_msb = 0; c_in_tag = '0; c_out_ready = 0;

    st_data[0] = 32'h0000_0001; st_one[0] = 0; st_msb[0] = 0; st_cnt[0] = 0;  st_all[0] = 0;
    st_data[1] = 32'h0000_0008; st_one[1] = 0; st_msb[1] = 0; st_cnt[1] = 3;  st_all[1] = 0;
    st_data[2] = 32'h8000_0000; st_one[2] = 0; st_msb[2] = 1; st_cnt[2] = 0;  st_all[2] = 0;
    st_data[3] = 32'h00F0_0000; st_one[3] = 0; st_msb[3] = 1; st_cnt[3] = 8;  st_all[3] = 0;
    st_data[4] = 32'h0000_000F; st_one[4] = 1; st_msb[4] = 0; st_cnt[4] = 4;  st_all[4] = 0;
    st_data[5] = 32'hFFFF_0000; st_one[5] = 1; st_msb[5] = 1; st_cnt[5] = 16; st_all[5] = 0;
    st_data[6] = 32'hFFFF_FFFF; st_one[6] = 1; st_msb[6] = 0; st_cnt[6] = 32; st_all[6] = 1;
    st_data[7] = 32'h0000_0000; st_one[7] = 0; st_msb[7] = 1; st_cnt[7] = 32; st_all[7] = 1;

    // Reset state
    #12;
    check_eq("rst_valid", 64'(a_out_valid), 64'd0);
    check_eq("rst_cnt", 64'(a_out_cnt), 64'd0);
    check_eq("rst_all", 64'(a_out_all), 64'd0);
    check_eq("rst_tag", 64'(a_out_tag), 64'd0);
    check_eq("rst_b_valid", 64'(b_out_valid), 64'd0);
    rst = 1'b0;

    // W=32 directed
    a_single("a_z_lsb", 32'h0001_0000, 1'b0, 1'b0, 6'd1, 16, 1'b0);
    a_single("a_z_msb", 32'h0001_0000, 1'b0, 1'b1, 6'd2, 15, 1'b0);
    a_single("a_o_full", 32'hFFFF_FFFF, 1'b1, 1'b0, 6'd3, 32, 1'b1);
    a_single("a_o_none", 32'h0000_0000, 1'b1, 1'b0, 6'd4, 0, 1'b0);
    a_single("a_z_full", 32'h0000_0000, 1'b0, 1'b0, 6'd5, 32, 1'b1);
    a_single("a_o_msb", 32'hFFFF_FFFE, 1'b1, 1'b1, 6'd6, 31, 1'b0);

    // W=20 directed
    b_single("b_z_msb_all", 20'h00000, 1'b0, 1'b1, 4'd1, 20, 1'b1);
    b_single("b_z_msb", 20'h00800, 1'b0, 1'b1, 4'd2, 8, 1'b0);
    b_single("b_o_lsb", 20'h7FFFF, 1'b1, 1'b0, 4'd3, 19, 1'b0);
    b_single("b_o_all", 20'hFFFFF, 1'b1, 1'b1, 4'd4, 20, 1'b1);

    // Backpressure: ready 1-on/2-off, results in order and held while stalled
    tx = 0; rx = 0; p_stall = 1'b0; p_snap = '0;
    for (int cyc = 0; cyc < 120 && rx < 8; cyc++) begin
      @(posedge clk); #1;
      a_out_ready = (cyc % 3 == 0);
      a_in_valid  = (tx < 8);
      if (tx < 8) a_drive_st(tx, 6'(tx));
      @(negedge clk);
      if (p_stall) begin
        check_eq("stall_valid", 64'(a_out_valid), 64'd1);
        check_eq("stall_hold", 64'({a_out_tag, a_out_cnt, a_out_all}), 64'(p_snap));
      end
      if (a_in_valid && a_in_ready) tx++;
      if (a_out_valid && a_out_ready) begin
        check_eq("stream_tag", 64'(a_out_tag), 64'(rx));
        check_eq("stream_cnt", 64'(a_out_cnt), 64'(st_cnt[rx]));
        check_eq("stream_all", 64'(a_out_all), 64'(st_all[rx]));
        rx++;
      end
      p_stall = a_out_valid && !a_out_ready;
      p_snap  = {a_out_tag, a_out_cnt, a_out_all};
    end
    check_eq("stream_count", 64'(rx), 64'd8);

    // Fill with out_ready low: exactly PIPE_STAGES accepted
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      a_out_ready = 1'b0; a_in_valid = 1'b1;
      a_drive_st(acc % 8, 6'(30 + acc));
      @(negedge clk);
      if (a_in_valid && a_in_ready) acc++;
    end
    check_eq("fill_accepts", 64'(acc), 64'(SA));
    check_eq("fill_ready_low", 64'(a_in_ready), 64'd0);
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_out_valid && a_out_ready) begin
        check_eq("fill_drain_tag", 64'(a_out_tag), 64'(30 + got));
        got++;
      end
      @(posedge clk); #1;
    end
    check_eq("fill_drain_count", 64'(got), 64'(SA));

    // Flush: two entries in flight plus a third offered with flush
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_drive_st(1, 6'd10);
    @(posedge clk); #1;
    a_drive_st(2, 6'd11);
    @(posedge clk); #1;
    a_drive_st(3, 6'd12); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; a_in_valid = 1'b0;
    check_eq("flush_clears", 64'(a_out_valid), 64'd0);
    a_out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_out_valid) seen++;
    end
    check_eq("flush_no_tags", 64'(seen), 64'd0);

    // Flush on the same edge as an accept into an empty pipe
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_drive_st(4, 6'd13); flush = 1'b1;
    @(negedge clk);
    check_eq("flush_acc_ready", 64'(a_in_ready), 64'd1);
    @(posedge clk); #1;
    a_in_valid = 1'b0; flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_out_valid) seen++;
    end
    check_eq("flush_acc_dropped", 64'(seen), 64'd0);

    // Asynchronous reset mid-stream
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_in_data = 32'h0000_0010; a_in_one = 1'b0; a_in_msb = 1'b0;
    a_in_tag = 6'd21; a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("arst_pre_valid", 64'(a_out_valid), 64'd1);
    check_eq("arst_pre_cnt", 64'(a_out_cnt), 64'd4);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", 64'(a_out_valid), 64'd0);
    check_eq("arst_tag", 64'(a_out_tag), 64'd0);
    check_eq("arst_cnt", 64'(a_out_cnt), 64'd0);
    #1 rst = 1'b0;
    a_single("a_after_rst", 32'h0000_0100, 1'b0, 1'b0, 6'd22, 8, 1'b0);

    // W=13, S=4: random modes and ready against the reference model
    c_done = 1'b0; ctag_n = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      if (c_done) begin
        c_in_valid = 1'b0;
        c_done     = 1'b0;
      end
      c_out_ready = (cyc >= 300) ? 1'b1 : 1'($urandom_range(0, 1));
      if (!c_in_valid && cyc < 300 && $urandom_range(0, 3) != 0) begin
        logic [12:0] v;
        int          k;
        k = $urandom_range(0, 13);
        v = 13'($urandom);
        v = ($urandom_range(0, 1) != 0) ? (v >> k) : (v << k);
        c_in_one = 1'($urandom_range(0, 1));
        c_in_msb = 1'($urandom_range(0, 1));
        if (c_in_one) v = ~v;
        c_in_data  = v;
        c_in_tag   = 6'(ctag_n);
        c_in_valid = 1'b1;
      end
      @(negedge clk);
      if (c_in_valid && c_in_ready) begin
        q_tag.push_back(int'(c_in_tag));
        q_cnt.push_back(ref_cnt(64'(c_in_data), 13, c_in_one, c_in_msb));
        c_done = 1'b1;
        ctag_n++;
      end
      if (c_out_valid && c_out_ready) begin
        if (q_tag.size() == 0) begin
          check_eq("c_extra", 64'(q_tag.size()), 64'd1);
        end else begin
          int et, ec;
          et = q_tag.pop_front();
          ec = q_cnt.pop_front();
          check_eq("c_tag", 64'(c_out_tag), 64'(et));
          check_eq("c_cnt", 64'(c_out_cnt), 64'(ec));
          check_eq("c_all", 64'(c_out_all), 64'(ec == 13));
        end
      end
    end
    check_eq("c_drained", 64'(q_tag.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
